// File: rtl/led_scroll_pkg.sv
// Shared types and sizing helpers for the bouncing-window LED scroller.
package led_scroll_pkg;

    typedef enum logic {
        DIR_LSB = 1'b0,
        DIR_MSB = 1'b1
    } dir_e;

    typedef enum logic {
        BOUNCE = 1'b0,
        WRAP   = 1'b1
    } mode_e;

    localparam int unsigned BOUNCE_CNT_W = 8;

    // Prescaler width for the larger divider; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned div_a, input int unsigned div_b);
        int unsigned w_max;
        int unsigned w_bits;
        w_max  = (div_a > div_b) ? div_a : div_b;
        w_bits = $clog2(w_max);
        return (w_bits == 0) ? 1 : w_bits;
    endfunction

endpackage

// File: rtl/led_bouncer_if.sv
// Control/LED bundle of led_bouncer; bounce_cnt exists only with LED_BOUNCER_BOUNCE_CNT_EN.
interface led_bouncer_if #(
    parameter int unsigned N_LED = 8
);
    import led_scroll_pkg::*;

    logic             run;
    logic             step;
    mode_e            mode;
    logic [N_LED-1:0] led_red;
    logic [N_LED-1:0] led_green;
    dir_e             dir;
    logic             tick;
`ifdef LED_BOUNCER_BOUNCE_CNT_EN
    logic [BOUNCE_CNT_W-1:0] bounce_cnt;
`endif

    modport master (
        output run, step, mode,
        input  led_red, led_green, dir, tick
`ifdef LED_BOUNCER_BOUNCE_CNT_EN
        , input bounce_cnt
`endif
    );

    modport slave (
        input  run, step, mode,
        output led_red, led_green, dir, tick
`ifdef LED_BOUNCER_BOUNCE_CNT_EN
        , output bounce_cnt
`endif
    );

endinterface

// File: rtl/led_tick_gen.sv
// Step prescaler: free-running enable tick while running, single steps while frozen.
module led_tick_gen #(
    parameter int unsigned CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_step,
    input  logic [CNT_W-1:0] i_div_m1,
    input  logic             i_restart,
    output logic             o_fire_c,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // i_div_m1 is the terminal count (DIV-1) of the current direction.
    always_comb begin
        o_fire_c  = 1'b0;
        w_cnt_nxt = r_cnt;
        if (i_run) begin
            o_fire_c = (r_cnt == i_div_m1);
        end else begin
            o_fire_c = i_step;
        end
        if (o_fire_c || i_restart) begin
            w_cnt_nxt = '0;
        end else if (i_run) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            o_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            o_tick <= o_fire_c;
        end
    end

endmodule

// File: rtl/led_bouncer.sv
// Bouncing/wrapping W-bit window scroller over red (LSB-bound) and green (MSB-bound) LED banks.
// Optional reversal counter on bus.bounce_cnt when LED_BOUNCER_BOUNCE_CNT_EN is defined.
module led_bouncer
    import led_scroll_pkg::*;
#(
    parameter int unsigned N_LED    = 8,
    parameter int unsigned WIN      = 3,
    parameter int unsigned DIV_FAST = 1048576,
    parameter int unsigned DIV_SLOW = 8388608
) (
    input  logic          clk,
    input  logic          reset,
    led_bouncer_if.slave  bus
);

    localparam int unsigned POS_MAX = N_LED - WIN;
    localparam int unsigned POS_W   = $clog2(N_LED + 1);
    localparam int unsigned CNT_W   = cnt_width(DIV_FAST, DIV_SLOW);

    localparam logic [N_LED-1:0] WIN_MASK = N_LED'({WIN{1'b1}});
    localparam logic [N_LED-1:0] RST_WIN  = WIN_MASK << POS_MAX;
    localparam logic [CNT_W-1:0] FAST_M1  = CNT_W'(DIV_FAST - 1);
    localparam logic [CNT_W-1:0] SLOW_M1  = CNT_W'(DIV_SLOW - 1);

    logic [POS_W-1:0] r_pos;
    dir_e             r_dir;
    logic [N_LED-1:0] r_led_red;
    logic [N_LED-1:0] r_led_green;

    logic [POS_W-1:0] w_pos_nxt;
    dir_e             w_dir_nxt;
    logic [N_LED-1:0] w_win;
    logic [CNT_W-1:0] w_div_m1;
    logic             w_fire;
    logic             w_restart;
    logic             w_tick;

    assign w_div_m1  = (r_dir == DIR_MSB) ? SLOW_M1 : FAST_M1;
    assign w_restart = (w_dir_nxt != r_dir);

    led_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .i_run     (bus.run),
        .i_step    (bus.step),
        .i_div_m1  (w_div_m1),
        .i_restart (w_restart),
        .o_fire_c  (w_fire),
        .o_tick    (w_tick)
    );

    // Window motion: turning at an end also moves one place in the same step.
    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        if (w_fire) begin
            if (POS_MAX == 0) begin
                if (bus.mode == BOUNCE) begin
                    w_dir_nxt = (r_dir == DIR_LSB) ? DIR_MSB : DIR_LSB;
                end
            end else if (r_dir == DIR_LSB) begin
                if (r_pos != '0) begin
                    w_pos_nxt = r_pos - POS_W'(1);
                end else if (bus.mode == WRAP) begin
                    w_pos_nxt = POS_W'(POS_MAX);
                end else begin
                    w_dir_nxt = DIR_MSB;
                    w_pos_nxt = POS_W'(1);
                end
            end else begin
                if (r_pos != POS_W'(POS_MAX)) begin
                    w_pos_nxt = r_pos + POS_W'(1);
                end else if (bus.mode == WRAP) begin
                    w_pos_nxt = '0;
                end else begin
                    w_dir_nxt = DIR_LSB;
                    w_pos_nxt = POS_W'(POS_MAX - 1);
                end
            end
        end
    end

    assign w_win = WIN_MASK << w_pos_nxt;

    // LED banks are registered alongside pos/dir so they always match the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pos       <= POS_W'(POS_MAX);
            r_dir       <= DIR_LSB;
            r_led_red   <= RST_WIN;
            r_led_green <= '0;
        end else begin
            r_pos       <= w_pos_nxt;
            r_dir       <= w_dir_nxt;
            r_led_red   <= (w_dir_nxt == DIR_LSB) ? w_win : '0;
            r_led_green <= (w_dir_nxt == DIR_MSB) ? w_win : '0;
        end
    end

    assign bus.led_red   = r_led_red;
    assign bus.led_green = r_led_green;
    assign bus.dir       = r_dir;
    assign bus.tick      = w_tick;

`ifdef LED_BOUNCER_BOUNCE_CNT_EN
    logic [BOUNCE_CNT_W-1:0] r_bounce_cnt;

    // Saturating count of direction reversals.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bounce_cnt <= '0;
        end else if (w_restart && (r_bounce_cnt != '1)) begin
            r_bounce_cnt <= r_bounce_cnt + BOUNCE_CNT_W'(1);
        end
    end

    assign bus.bounce_cnt = r_bounce_cnt;
`endif

endmodule

// File: tb/tb_led_bouncer.sv
// Self-checking bench for led_bouncer: directed sweeps plus randomized run/step/mode/reset vs a model.
module tb_led_bouncer;
    import led_scroll_pkg::*;

    localparam int N    = 8;
    localparam int W    = 3;
    localparam int DF   = 2;
    localparam int DS   = 4;
    localparam int PMAX = N - W;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    int   m_pos;
    int   m_dir;
    int   m_cnt;
    logic m_tick;

    led_bouncer_if #(.N_LED(N)) bus  ();
    led_bouncer_if #(.N_LED(N)) bus2 ();

    led_bouncer #(.N_LED(N), .WIN(W), .DIV_FAST(DF), .DIV_SLOW(DS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    led_bouncer #(.N_LED(N), .WIN(N), .DIV_FAST(1), .DIV_SLOW(1)) dut_full (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] win_of(input int pos);
        logic [7:0] m;
        m = 8'h07;
        return m << pos;
    endfunction

    // One step of the window following the written movement rules.
    task automatic model_step(input logic wrap);
        int np;
        np = (m_dir == 1) ? m_pos + 1 : m_pos - 1;
        if (np < 0 || np > PMAX) begin
            if (wrap) begin
                np = (m_dir == 1) ? 0 : PMAX;
            end else begin
                m_dir = 1 - m_dir;
                np    = (m_dir == 1) ? 1 : PMAX - 1;
            end
        end
        m_pos = np;
    endtask

    task automatic cycle();
        logic fire;
        int   div;
        @(posedge clk);
        if (!reset) begin
            m_pos = PMAX; m_dir = 0; m_cnt = 0; m_tick = 1'b0;
        end else begin
            div  = (m_dir == 1) ? DS : DF;
            fire = bus.run ? (m_cnt == div - 1) : bus.step;
            if (fire) begin
                m_cnt = 0;
                model_step(bus.mode == WRAP);
            end else if (bus.run) begin
                m_cnt++;
            end
            m_tick = fire;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        bus.run   = 1'b0; bus.step  = 1'b0; bus.mode  = BOUNCE;
        bus2.run  = 1'b0; bus2.step = 1'b0; bus2.mode = BOUNCE;
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total += 6;
        if (bus.led_red !== 8'hE0) begin bad++; $display("FAIL reset_red: got %h want e0", bus.led_red); end
        if (bus.led_green !== 8'h00) begin bad++; $display("FAIL reset_green: got %h want 00", bus.led_green); end
        if (bus.dir !== DIR_LSB) begin bad++; $display("FAIL reset_dir: got %0d want 0", bus.dir); end
        if (bus.tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", bus.tick); end
        if (bus2.led_red !== 8'hFF) begin bad++; $display("FAIL reset_full_red: got %h want ff", bus2.led_red); end
        for (int i = 0; i < 4; i++) cycle();
        if (bus.led_red !== 8'hE0) begin bad++; $display("FAIL frozen_red: got %h want e0", bus.led_red); end
    endtask

    task automatic test_sweep();
        logic [7:0] ev   [11];
        logic       ered [11];
        int         egap [11];
        int         k;
        int         gap;
        ev   = '{8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70};
        ered = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        egap = '{2, 2, 2, 2, 2, 2, 4, 4, 4, 4, 4};
        do_reset();
        bus.run = 1'b1;
        k = 0; gap = 0;
        for (int c = 0; c < 200 && k < 11; c++) begin
            cycle();
            gap++;
            if (bus.tick === 1'b1) begin
                total += 2;
                if (bus.led_red !== (ered[k] ? ev[k] : 8'h00) || bus.led_green !== (ered[k] ? 8'h00 : ev[k])) begin
                    bad++;
                    $display("FAIL sweep_led[%0d]: got red=%h green=%h want %s=%h", k, bus.led_red, bus.led_green, ered[k] ? "red" : "green", ev[k]);
                end
                if (gap != egap[k]) begin
                    bad++;
                    $display("FAIL sweep_gap[%0d]: got %0d want %0d", k, gap, egap[k]);
                end
                k++; gap = 0;
            end
        end
        total++;
        if (k != 11) begin bad++; $display("FAIL sweep_timeout: got %0d steps want 11", k); end
        bus.run = 1'b0;
    endtask

    task automatic test_wrap();
        logic found;
        do_reset();
        bus.run = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            cycle();
            if (bus.tick === 1'b1 && bus.led_red === 8'h07) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL wrap_reach: got no 07 want 07"); end
        bus.mode = WRAP;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            cycle();
            if (bus.tick === 1'b1) found = 1'b1;
        end
        total += 3;
        if (!found || bus.led_red !== 8'hE0) begin bad++; $display("FAIL wrap_red: got %h want e0", bus.led_red); end
        if (bus.led_green !== 8'h00) begin bad++; $display("FAIL wrap_green: got %h want 00", bus.led_green); end
        if (bus.dir !== DIR_LSB) begin bad++; $display("FAIL wrap_dir: got %0d want 0", bus.dir); end
        bus.run = 1'b0;
    endtask

    task automatic test_manual_step();
        logic [7:0] ev [3];
        logic [7:0] cur;
        int         ticks;
        int         idle;
        ev = '{8'h70, 8'h38, 8'h1C};
        do_reset();
        cur = 8'hE0; ticks = 0;
        for (int p = 0; p < 3; p++) begin
            idle = int'($urandom_range(2, 6));
            for (int i = 0; i < idle; i++) begin
                cycle();
                if (bus.tick === 1'b1) ticks++;
                total++;
                if (bus.led_red !== cur) begin bad++; $display("FAIL step_hold: got %h want %h", bus.led_red, cur); end
            end
            bus.step = 1'b1;
            cycle();
            bus.step = 1'b0;
            if (bus.tick === 1'b1) ticks++;
            cur = ev[p];
            total++;
            if (bus.led_red !== cur) begin bad++; $display("FAIL step_led[%0d]: got %h want %h", p, bus.led_red, cur); end
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (bus.tick === 1'b1) ticks++;
        end
        total++;
        if (ticks != 3) begin bad++; $display("FAIL step_ticks: got %0d want 3", ticks); end
    endtask

    task automatic test_reset_mid();
        logic found;
        do_reset();
        bus.run = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            cycle();
            if (bus.led_green === 8'h38) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL rstmid_reach: got no green 38 want 38"); end
        reset = 1'b0;
        #1;
        total += 2;
        if (bus.led_red !== 8'hE0 || bus.led_green !== 8'h00) begin
            bad++; $display("FAIL rstmid_async: got red=%h green=%h want e0/00", bus.led_red, bus.led_green);
        end
        if (bus.tick !== 1'b0 || bus.dir !== DIR_LSB) begin
            bad++; $display("FAIL rstmid_async_ctl: got tick=%b dir=%0d want 0/0", bus.tick, bus.dir);
        end
        cycle();
        total++;
        if (bus.led_red !== 8'hE0 || bus.led_green !== 8'h00 || bus.dir !== DIR_LSB || bus.tick !== 1'b0) begin
            bad++; $display("FAIL rstmid_next: got red=%h green=%h dir=%0d tick=%b want e0/00/0/0", bus.led_red, bus.led_green, bus.dir, bus.tick);
        end
        reset = 1'b1;
        bus.run = 1'b0;
    endtask

    task automatic test_full_window();
        do_reset();
        bus2.run = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            total++;
            if ((i % 2) == 1) begin
                if (bus2.led_green !== 8'hFF || bus2.led_red !== 8'h00 || bus2.dir !== DIR_MSB) begin
                    bad++; $display("FAIL full_bounce[%0d]: got red=%h green=%h want green ff", i, bus2.led_red, bus2.led_green);
                end
            end else begin
                if (bus2.led_red !== 8'hFF || bus2.led_green !== 8'h00 || bus2.dir !== DIR_LSB) begin
                    bad++; $display("FAIL full_bounce[%0d]: got red=%h green=%h want red ff", i, bus2.led_red, bus2.led_green);
                end
            end
        end
        bus2.mode = WRAP;
        for (int i = 0; i < 4; i++) begin
            cycle();
            total++;
            if (bus2.led_red !== 8'hFF || bus2.dir !== DIR_LSB || bus2.tick !== 1'b1) begin
                bad++; $display("FAIL full_wrap[%0d]: got red=%h dir=%0d tick=%b want ff/0/1", i, bus2.led_red, bus2.dir, bus2.tick);
            end
        end
        bus2.run = 1'b0;
    endtask

`ifdef LED_BOUNCER_BOUNCE_CNT_EN
    task automatic test_bounce_cnt();
        do_reset();
        total += 3;
        if (bus2.bounce_cnt !== 8'd0) begin bad++; $display("FAIL bcnt_reset: got %0d want 0", bus2.bounce_cnt); end
        bus2.run = 1'b1;
        for (int i = 0; i < 100; i++) cycle();
        if (bus2.bounce_cnt !== 8'd100) begin bad++; $display("FAIL bcnt_100: got %0d want 100", bus2.bounce_cnt); end
        for (int i = 0; i < 200; i++) cycle();
        if (bus2.bounce_cnt !== 8'd255) begin bad++; $display("FAIL bcnt_sat: got %0d want 255", bus2.bounce_cnt); end
        bus2.run = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [7:0] er;
        logic [7:0] eg;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 199) == 0) reset = 1'b0;
            bus.run  = ($urandom_range(0, 9) < 6);
            bus.step = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) bus.mode = (bus.mode == BOUNCE) ? WRAP : BOUNCE;
            cycle();
            er = (m_dir == 0) ? win_of(m_pos) : 8'h00;
            eg = (m_dir == 1) ? win_of(m_pos) : 8'h00;
            total++;
            if (bus.led_red !== er || bus.led_green !== eg || bus.dir !== dir_e'(m_dir[0]) || bus.tick !== m_tick) begin
                bad++;
                $display("FAIL rand[%0d]: got red=%h green=%h dir=%0d tick=%b want red=%h green=%h dir=%0d tick=%b",
                         c, bus.led_red, bus.led_green, bus.dir, bus.tick, er, eg, m_dir, m_tick);
            end
        end
        reset = 1'b1;
        bus.run = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sweep();
        test_wrap();
        test_manual_step();
        test_reset_mid();
        test_full_window();
`ifdef LED_BOUNCER_BOUNCE_CNT_EN
        test_bounce_cnt();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
